// File: rtl/ysyx_22050598_ifu_bht_pkg.sv
// rtl/ysyx_22050598_ifu_bht_pkg.sv - shared opcodes, counter encodings and immediate decode for the IF branch predictor
package ysyx_22050598_ifu_bht_pkg;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    localparam int         CNT_W = 2;
    localparam logic [1:0] SNT   = 2'b00;
    localparam logic [1:0] WNT   = 2'b01;
    localparam logic [1:0] WT    = 2'b10;
    localparam logic [1:0] ST    = 2'b11;

    // B-type immediate, sign-extended, bit0 forced to zero
    function automatic logic [63:0] bimm(input logic [31:0] inst);
        return {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // J-type immediate, sign-extended, bit0 forced to zero
    function automatic logic [63:0] jimm(input logic [31:0] inst);
        return {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ysyx_22050598_sat_cnt2.sv
// rtl/ysyx_22050598_sat_cnt2.sv - 2-bit saturating counter next-state logic
module ysyx_22050598_sat_cnt2
    import ysyx_22050598_ifu_bht_pkg::*;
(
    input  logic [CNT_W-1:0] cnt,
    input  logic             taken,
    output logic [CNT_W-1:0] next_cnt
);

    // move one step toward the outcome, holding at either end
    always_comb begin
        next_cnt = cnt;
        if (taken) begin
            if (cnt != ST) next_cnt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) next_cnt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/ysyx_22050598_ifu_bht.sv
// rtl/ysyx_22050598_ifu_bht.sv - BHT branch predictor with imm decode; optional gshare via YSYX_22050598_BPU_GSHARE_EN
module ysyx_22050598_ifu_bht
    import ysyx_22050598_ifu_bht_pkg::*;
#(
    parameter int          BHT_DEPTH = 64,
    parameter logic [1:0]  INIT_CNT  = 2'b01,
    parameter int          PERF_W    = 32,
    localparam int         IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       if_pc,
    input  logic [31:0]       if_inst,
    output logic [63:0]       bpu_pc_add_op,
    output logic              prdt_taken,
    output logic [IDX_W-1:0]  prdt_idx,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_mispred,
    output logic [PERF_W-1:0] perf_br_cnt,
    output logic [PERF_W-1:0] perf_mis_cnt
);

    logic [CNT_W-1:0]  bht [BHT_DEPTH];
    logic [CNT_W-1:0]  upd_next;
    logic [IDX_W-1:0]  pc_idx;
    logic [PERF_W-1:0] br_cnt_q;
    logic [PERF_W-1:0] mis_cnt_q;
    logic              is_jal;
    logic              is_bxx;
    logic              unused_pc_bits;

    assign pc_idx         = if_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[63:IDX_W+2], if_pc[1:0]};
    assign is_jal         = (if_inst[6:0] == OPCODE_JAL);
    assign is_bxx         = (if_inst[6:0] == OPCODE_BRANCH);

`ifdef YSYX_22050598_BPU_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // history is shifted only at resolution, so it never needs a wrong-path repair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ghr <= '0;
        else if (upd_valid) ghr <= {ghr[IDX_W-2:0], upd_taken};
    end

    assign prdt_idx = pc_idx ^ ghr;
`else
    assign prdt_idx = pc_idx;
`endif

    // one shared next-state block: at most one entry trains per cycle
    ysyx_22050598_sat_cnt2 u_sat_cnt2 (
        .cnt      (bht[upd_idx]),
        .taken    (upd_taken),
        .next_cnt (upd_next)
    );

    // counter table in flops so reset returns every entry to INIT_CNT at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= INIT_CNT;
        end else if (upd_valid) begin
            bht[upd_idx] <= upd_next;
        end
    end

    // resolved / mispredicted branch counters, wrapping freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (upd_valid) begin
            br_cnt_q <= br_cnt_q + PERF_W'(1);
            if (upd_mispred) mis_cnt_q <= mis_cnt_q + PERF_W'(1);
        end
    end

    assign perf_br_cnt  = br_cnt_q;
    assign perf_mis_cnt = mis_cnt_q;

    // zero-cycle prediction; reads the pre-update table value with no bypass
    always_comb begin
        prdt_taken    = 1'b0;
        bpu_pc_add_op = 64'd0;
        if (is_jal) begin
            prdt_taken    = 1'b1;
            bpu_pc_add_op = jimm(if_inst);
        end else if (is_bxx) begin
            prdt_taken    = bht[prdt_idx][1];
            bpu_pc_add_op = bimm(if_inst);
        end
    end

endmodule

// File: tb/tb_ysyx_22050598_ifu_bht.sv
// tb/tb_ysyx_22050598_ifu_bht.sv - scoreboard bench for the BHT predictor
module tb_ysyx_22050598_ifu_bht;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic [63:0] bpu_pc_add_op;
    logic        prdt_taken;
    logic [5:0]  prdt_idx;
    logic        upd_valid = 1'b0;
    logic [5:0]  upd_idx = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispred = 1'b0;
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mis_cnt;

    ysyx_22050598_ifu_bht dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .bpu_pc_add_op (bpu_pc_add_op),
        .prdt_taken    (prdt_taken),
        .prdt_idx      (prdt_idx),
        .upd_valid     (upd_valid),
        .upd_idx       (upd_idx),
        .upd_taken     (upd_taken),
        .upd_mispred   (upd_mispred),
        .perf_br_cnt   (perf_br_cnt),
        .perf_mis_cnt  (perf_mis_cnt)
    );

    always #5 clk = ~clk;

`ifdef YSYX_22050598_BPU_GSHARE_EN
    bit gshare = 1'b1;
`else
    bit gshare = 1'b0;
`endif

    typedef struct {
        logic [63:0] off;
        logic        taken;
        logic [5:0]  idx;
        logic [31:0] br;
        logic [31:0] mis;
    } exp_t;

    exp_t  expq[$];
    string nameq[$];
    int    tests = 0;
    int    fails = 0;

    // reference model state
    int          mcnt[64];
    int          mghr = 0;
    logic [31:0] mbr = '0;
    logic [31:0] mmis = '0;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) mcnt[i] = 1;
        mghr = 0;
        mbr  = '0;
        mmis = '0;
    endfunction

    function automatic logic [31:0] enc_b(input logic [63:0] off);
        return {off[12], off[10:5], 5'd3, 5'd2, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [63:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'b1101111};
    endfunction

    // kind: 0 = not predicted, 1 = jal, 2 = conditional branch
    task automatic drive(input string nm, input bit rst_low, input logic [63:0] pc,
                         input logic [31:0] inst, input int kind, input logic [63:0] off,
                         input bit uv, input int uidx, input bit ut, input bit um);
        exp_t e;
        int   idx;
        @(posedge clk);
        #1;
        rst_n       = !rst_low;
        if_pc       = pc;
        if_inst     = inst;
        upd_valid   = uv;
        upd_idx     = uidx[5:0];
        upd_taken   = ut;
        upd_mispred = um;
        if (rst_low) model_reset();
        idx   = int'((pc >> 2) % 64) ^ (gshare ? mghr : 0);
        e.idx = idx[5:0];
        e.br  = mbr;
        e.mis = mmis;
        case (kind)
            1:       begin e.taken = 1'b1;           e.off = off; end
            2:       begin e.taken = (mcnt[idx] >= 2); e.off = off; end
            default: begin e.taken = 1'b0;           e.off = '0;  end
        endcase
        expq.push_back(e);
        nameq.push_back(nm);
        if (uv && !rst_low) begin
            mcnt[uidx % 64] = ut ? ((mcnt[uidx % 64] + 1 > 3) ? 3 : mcnt[uidx % 64] + 1)
                                 : ((mcnt[uidx % 64] - 1 < 0) ? 0 : mcnt[uidx % 64] - 1);
            mghr = ((mghr * 2) + int'(ut)) % 64;
            mbr  = mbr + 32'd1;
            if (um) mmis = mmis + 32'd1;
        end
    endtask

    function automatic void chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endfunction

    // monitor: one expectation per cycle, compared away from the active edge
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t  e;
            string nm;
            e  = expq.pop_front();
            nm = nameq.pop_front();
            chk(nm, "taken", 64'(prdt_taken), 64'(e.taken));
            chk(nm, "offset", bpu_pc_add_op, e.off);
            chk(nm, "idx", 64'(prdt_idx), 64'(e.idx));
            chk(nm, "br_cnt", 64'(perf_br_cnt), 64'(e.br));
            chk(nm, "mis_cnt", 64'(perf_mis_cnt), 64'(e.mis));
        end
    end

    localparam logic [63:0] PC_I4 = 64'h8000_0010;
    localparam logic [63:0] PC_I7 = 64'h8000_001C;
    localparam logic [63:0] PC_I5 = 64'h8000_0014;

    initial begin
        logic [63:0] m8;
        logic [63:0] p100;
        logic [31:0] b4;
        logic [31:0] b7;
        logic [31:0] jalr_i;
        logic [6:0]  ops[4];
        model_reset();
        m8     = -64'sd8;
        p100   = 64'h100;
        b4     = enc_b(m8);
        b7     = enc_b(64'h20);
        jalr_i = {12'h010, 5'd1, 3'b000, 5'd0, 7'b1100111};
        ops[0] = 7'b0010011; ops[1] = 7'b0110011; ops[2] = 7'b1100111; ops[3] = 7'b0000011;

        drive("reset_bxx", 1, PC_I4, b4, 2, m8, 0, 0, 0, 0);
        drive("train_t1", 0, PC_I4, b4, 2, m8, 1, 4, 1, 0);
        drive("train_t2", 0, PC_I4, b4, 2, m8, 1, 4, 1, 0);
        drive("pred_st", 0, PC_I4, b4, 2, m8, 1, 4, 0, 1);
        drive("train_n2", 0, PC_I4, b4, 2, m8, 1, 4, 0, 0);
        drive("train_n3", 0, PC_I4, b4, 2, m8, 1, 4, 0, 0);
        drive("train_n4", 0, PC_I4, b4, 2, m8, 1, 4, 0, 1);
        drive("sat_low", 0, PC_I4, b4, 2, m8, 0, 0, 0, 0);
        drive("jal", 0, 64'h8000_1234, enc_j(p100), 1, p100, 0, 0, 0, 0);
        drive("jalr", 0, 64'h8000_0040, jalr_i, 0, 0, 0, 0, 0, 0);
        drive("same_cyc0", 0, PC_I7, b7, 2, 64'h20, 1, 7, 1, 0);
        drive("same_cyc1", 0, PC_I7, b7, 2, 64'h20, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            drive("perf10", 0, 64'h8000_0100, 32'h0000_0013, 0, 0, 1, 20 + i, i[0], (i < 3));
        drive("perf_done", 0, 64'h8000_0100, 32'h0000_0013, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        force dut.br_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_cnt_q;
        mbr = 32'hFFFF_FFFF;
        drive("wrap_pre", 0, 64'h8000_0100, 32'h0000_0013, 0, 0, 1, 30, 1, 0);
        drive("wrap_post", 0, 64'h8000_0100, 32'h0000_0013, 0, 0, 0, 0, 0, 0);

        drive("ghr_rst", 1, PC_I5, b4, 2, m8, 0, 0, 0, 0);
        drive("ghr_t1", 0, PC_I5, b4, 2, m8, 1, 9, 1, 0);
        drive("ghr_t2", 0, PC_I5, b4, 2, m8, 1, 9, 1, 0);
        drive("ghr_n", 0, PC_I5, b4, 2, m8, 1, 9, 0, 0);
        drive("ghr_idx", 0, PC_I5, b4, 2, m8, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            int          kind;
            logic [63:0] pc;
            logic [63:0] off;
            logic [31:0] inst;
            pc   = 64'h8000_0000 + 64'($urandom_range(0, 255) * 4);
            kind = $urandom_range(0, 2);
            if (kind == 1) begin
                off  = 64'((longint'($urandom_range(0, 1048575)) - 524288) * 2);
                inst = enc_j(off);
            end else if (kind == 2) begin
                off  = 64'((longint'($urandom_range(0, 4095)) - 2048) * 2);
                inst = enc_b(off);
            end else begin
                off  = '0;
                inst = {$urandom_range(0, 33554431) , 7'b0} >> 7;
                inst = {inst[24:0], ops[$urandom_range(0, 3)]};
            end
            drive((i == 200) ? "mid_reset" : "random", (i == 200), pc, inst, kind, off,
                  ($urandom_range(0, 1) == 1), $urandom_range(0, 63),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
        end
        drive("tail", 0, 64'h8000_0000, 32'h0000_0013, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_22050598_ifu_bht.md
Name: ysyx_22050598_ifu_bht

Overview:
- Dynamic branch predictor for the IF stage: table of 2-bit saturating counters (BHT) plus immediate decode of the fetched instruction.
- Prediction is combinational from fetch PC and instruction; training is sequential from EX-stage branch resolution.
- Output feeds the IF next-PC adder.
- Replaces static backward-taken prediction with per-PC history; adds mispredict performance counters.

Parameters:
- BHT_DEPTH, 64, number of counter entries; power of 2, range 4..1024.
- IDX_W, $clog2(BHT_DEPTH), index width; derived, never overridden.
- INIT_CNT, 2'b01, counter reset value (01 = weakly not-taken).
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  64  PC of the fetched instruction.
- if_inst  in  32  fetched instruction.
- bpu_pc_add_op  out  64  offset added to if_pc for the predicted next PC: Jimm for jal, Bimm for branches, 0 otherwise.
- prdt_taken  out  1  predicted taken.
- prdt_idx  out  IDX_W  BHT index used for this prediction; carried down the pipeline.
- upd_valid  in  1  one branch resolved this cycle (EX stage, single pulse per branch).
- upd_idx  in  IDX_W  prdt_idx carried with the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_mispred  in  1  prediction was wrong (redirect occurred).
- perf_br_cnt  out  PERF_W  resolved conditional branches.
- perf_mis_cnt  out  PERF_W  mispredicted conditional branches.

Behaviour:
- Decode:
  - jal = opcode 1101111; bxx = opcode 1100011.
  - Bimm and Jimm are RISC-V B/J immediates, sign-extended to 64 bits, bit0 = 0.
  - jalr is not predicted: prdt_taken = 0, offset = 0; the pipeline stalls on jalr elsewhere.
- Index:
  - prdt_idx = if_pc[IDX_W+1:2].
  - With the optional feature, prdt_idx = if_pc[IDX_W+1:2] XOR ghr.
- Prediction (combinational, 0-cycle):
  - jal: taken = 1.
  - bxx: taken = bht[prdt_idx][1].
  - others: taken = 0, offset = 0.
- Update (1 cycle latency): on a rising edge with upd_valid = 1:
  - upd_taken = 1: bht[upd_idx] increments, saturating at 11.
  - upd_taken = 0: bht[upd_idx] decrements, saturating at 00.
  - Only conditional branches assert upd_valid; jal never trains.
- Read/write same index, same cycle: prediction uses the pre-update value; the new value is visible the next cycle. No bypass.
- Perf counters:
  - perf_br_cnt += 1 on each upd_valid.
  - perf_mis_cnt += 1 when upd_valid & upd_mispred.
  - Both wrap modulo 2^PERF_W; no saturation.
  - upd_mispred without upd_valid is ignored.
- Reset (async assert, sync deassert handled externally):
  - all bht entries = INIT_CNT.
  - perf counters = 0.
  - ghr = 0.
  - Combinational outputs follow their inputs during reset, using reset table contents.
- Reset mid-operation: an in-flight update is dropped; the table returns to INIT_CNT immediately.
- Storage: flops, not SRAM, so the reset clear is single-cycle.

Optional Feature:
- Macro: YSYX_22050598_BPU_GSHARE_EN.
- Defined:
  - Adds IDX_W-bit global history register ghr.
  - On upd_valid, ghr <= {ghr[IDX_W-2:0], upd_taken}; history is trained non-speculatively at resolution.
  - prdt_idx uses PC XOR ghr.
- Undefined:
  - No ghr flops; prdt_idx = PC bits only.
  - Ports are identical in both builds.

Decomposition:
- Shared defines header carries:
  - OPCODE_JAL and OPCODE_BRANCH (existing).
  - New constants: counter width (2), counter encodings SNT=00, WNT=01, WT=10, ST=11.
- One sub-module: ysyx_22050598_sat_cnt2.
  - 2-bit saturating counter update function: inputs cnt, taken; output next.
  - Instantiated per entry or used as shared next-state logic.
- Top module holds the table, index logic, ghr and perf counters.

Test Plan:
- Reset, then fetch bxx at pc 0x80000010 with Bimm = -8 -> prdt_taken = 0, bpu_pc_add_op = 0xFFFF_FFFF_FFFF_FFF8, prdt_idx = 4 (non-gshare).
- Two upd_valid pulses on idx 4 with taken = 1 -> counter 01→10→11; the same bxx now predicts taken. Three further not-taken updates -> 11→10→01→00; a fourth not-taken update stays at 00.
- jal at any PC with J offset +0x100 -> prdt_taken = 1, offset = 0x100, independent of table state. jalr -> taken = 0, offset = 0.
- Same-cycle fetch on idx 7 (counter 01) and update idx 7 taken -> prediction 0 this cycle, 1 next cycle.
- 10 updates with 3 mispredicts -> perf_br_cnt = 10, perf_mis_cnt = 3. Preload perf_br_cnt = 2^32-1 (force) plus one update -> wraps to 0.
- Gshare build: updates T, T, N give ghr = 3'b110 in the low bits. Fetch pc with PC index 5 -> prdt_idx = 5 XOR 6 = 3. Assert rst_n = 0 mid-run -> ghr = 0 and all counters 01 without a clock edge.
